// File: rtl/clock_pkg.sv
// Shared BCD types and helpers for the clock/alarm datapath counters.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t HOUR_MAX_TENS             = 4'd2;
  localparam bcd_t HOUR_MAX_ONES_AT_MAX_TENS = 4'd3;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} key_state_e;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } hour_t;

  typedef struct packed {
    logic pm;
    bcd_t tens;
    bcd_t ones;
  } disp_t;

  function automatic logic is_last_hour(hour_t h);
    return (h.tens == HOUR_MAX_TENS) && (h.ones == HOUR_MAX_ONES_AT_MAX_TENS);
  endfunction

  function automatic hour_t bcd_inc_hour(hour_t h);
    hour_t r;
    r = h;
    if (is_last_hour(h)) begin
      r = '0;
    end else if (h.ones == 4'd9) begin
      r.tens = h.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.ones = h.ones + 4'd1;
    end
    return r;
  endfunction

  // 00 shows as 12 AM, 12 as 12 PM, 13-23 fold down to 01-11 PM.
  function automatic disp_t to_12h(hour_t h, logic mode_12h);
    logic [4:0] bin;
    logic [4:0] r;
    disp_t      d;
    bin    = 5'(h.tens) * 5'd10 + 5'(h.ones);
    r      = bin;
    d.pm   = 1'b0;
    d.tens = h.tens;
    d.ones = h.ones;
    if (mode_12h) begin
      d.pm = (bin >= 5'd12);
      if (bin == 5'd0) begin
        r = 5'd12;
      end else if (bin > 5'd12) begin
        r = bin - 5'd12;
      end
      d.tens = (r >= 5'd10) ? 4'd1 : 4'd0;
      d.ones = (r >= 5'd10) ? 4'(r - 5'd10) : 4'(r);
    end
    return d;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Key synchroniser with press detection and hold-to-auto-repeat; emits single-cycle inc pulses.
module key_repeat
  import clock_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 200,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic key_n_i,
  output logic inc_pulse_o
);

  localparam int unsigned MaxCount = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TimerW   = $clog2(MaxCount + 1);
  localparam logic [TimerW-1:0] DelayLast  = TimerW'(REPEAT_DELAY - 1);
  localparam logic [TimerW-1:0] PeriodLast = TimerW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed, pressed_q, press_edge;
  key_state_e             state_q, state_d;
  logic [TimerW-1:0]      timer_q, timer_d, timer_inc;

  assign pressed    = ~sync_q[SYNC_STAGES-1];
  assign press_edge = pressed & ~pressed_q;
  assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    inc_pulse_o = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press_edge) begin
            inc_pulse_o = 1'b1;
            state_d     = DELAY;
            timer_d     = '0;
          end
        end
        DELAY: begin
          if (!pressed) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == DelayLast) begin
            inc_pulse_o = 1'b1;
            state_d     = REPEAT;
            timer_d     = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        REPEAT: begin
          if (!pressed) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == PeriodLast) begin
            inc_pulse_o = 1'b1;
            timer_d     = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Synchroniser idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '1;
      pressed_q <= 1'b0;
      state_q   <= IDLE;
      timer_q   <= '0;
    end else begin
      sync_q    <= SYNC_STAGES'({sync_q, key_n_i});
      pressed_q <= pressed;
      state_q   <= state_d;
      timer_q   <= timer_d;
    end
  end

endmodule

// File: rtl/hour_counter_24.sv
// BCD 00-23 hour counter with carry-edge run mode, key set mode and registered 12/24 h display.
module hour_counter_24
  import clock_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 200,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN_work,
  input  logic       EN_set,
  input  logic       hour_CIN,
  input  logic       key_inc,
  input  logic       mode_12h,
  output logic [3:0] hour_ones,
  output logic [3:0] hour_tens,
  output logic [3:0] disp_ones,
  output logic [3:0] disp_tens,
  output logic       pm,
  output logic       day_COUT
);

  logic  set_mode, run_mode, cin_q, cin_rise, key_pulse, run_inc, inc;
  logic  day_q, day_d;
  hour_t hour_q, hour_d;
  disp_t disp_q, disp_d;

  assign set_mode = ~EN_set;
  assign run_mode = ~EN_work & EN_set;
  assign cin_rise = hour_CIN & ~cin_q;
  assign run_inc  = run_mode & cin_rise;
  assign inc      = set_mode ? key_pulse : run_inc;

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_key_repeat (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (set_mode),
    .key_n_i    (key_inc),
    .inc_pulse_o(key_pulse)
  );

  always_comb begin
    hour_d = inc ? bcd_inc_hour(hour_q) : hour_q;
    day_d  = run_inc & is_last_hour(hour_q);
    disp_d = to_12h(hour_q, mode_12h);
  end

  // cin_q resets high so a carry already asserted at reset release is not an edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hour_q <= '0;
      disp_q <= '0;
      day_q  <= 1'b0;
      cin_q  <= 1'b1;
    end else begin
      hour_q <= hour_d;
      disp_q <= disp_d;
      day_q  <= day_d;
      cin_q  <= hour_CIN;
    end
  end

  assign hour_ones = hour_q.ones;
  assign hour_tens = hour_q.tens;
  assign disp_ones = disp_q.ones;
  assign disp_tens = disp_q.tens;
  assign pm        = disp_q.pm;
  assign day_COUT  = day_q;

endmodule

// File: tb/tb_hour_counter_24.sv
// Scoreboard bench for hour_counter_24: integer-hour reference model, per-cycle checking.
module tb_hour_counter_24;

  localparam int D = 5;
  localparam int P = 3;
  localparam int S = 2;

  logic       CLK, RST, EN_work, EN_set, hour_CIN, key_inc, mode_12h;
  logic [3:0] hour_ones, hour_tens, disp_ones, disp_tens;
  logic       pm, day_COUT;

  hour_counter_24 #(
    .REPEAT_DELAY (D),
    .REPEAT_PERIOD(P),
    .SYNC_STAGES  (S)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN_work  (EN_work),
    .EN_set   (EN_set),
    .hour_CIN (hour_CIN),
    .key_inc  (key_inc),
    .mode_12h (mode_12h),
    .hour_ones(hour_ones),
    .hour_tens(hour_tens),
    .disp_ones(disp_ones),
    .disp_tens(disp_tens),
    .pm       (pm),
    .day_COUT (day_COUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int hour;
    int disp;
    bit pm;
    bit day;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: hour as an integer, key behaviour as "cycles held since press".
  int   m_hour, m_hc, m_old, m_disp;
  bit   m_cin_prev, m_active, m_set, m_run, m_pr, m_pr_prev, m_inc, m_day;
  bit   m_kh[0:S];
  exp_t m_e;

  always @(posedge CLK) begin
    if (RST) begin
      m_hour     = 0;
      m_cin_prev = 1'b1;
      m_active   = 1'b0;
      m_hc       = 0;
      for (int i = 0; i <= S; i++) m_kh[i] = 1'b1;
      m_e = '{hour: 0, disp: 0, pm: 1'b0, day: 1'b0};
    end else begin
      m_set     = !EN_set;
      m_run     = !EN_work && EN_set;
      m_pr      = !m_kh[S-1];
      m_pr_prev = !m_kh[S];
      m_inc     = 1'b0;
      if (m_set) begin
        if (m_pr && !m_pr_prev) begin
          m_inc    = 1'b1;
          m_active = 1'b1;
          m_hc     = 0;
        end else if (m_active && m_pr) begin
          m_hc++;
          if (m_hc == D || (m_hc > D && (m_hc - D) % P == 0)) m_inc = 1'b1;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_active = 1'b0;
        if (m_run && hour_CIN && !m_cin_prev) m_inc = 1'b1;
      end
      m_day = m_run && m_inc && (m_hour == 23);
      m_old = m_hour;
      if (m_inc) m_hour = (m_hour + 1) % 24;
      if (mode_12h) m_disp = (m_old == 0) ? 12 : (m_old > 12) ? m_old - 12 : m_old;
      else          m_disp = m_old;
      m_e = '{hour: m_hour, disp: m_disp, pm: mode_12h && (m_old >= 12), day: m_day};
      for (int i = S; i > 0; i--) m_kh[i] = m_kh[i-1];
      m_kh[0]    = key_inc;
      m_cin_prev = hour_CIN;
    end
    sb_q.push_back(m_e);
  end

  exp_t mon_e;
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (int'(hour_tens) != mon_e.hour / 10 || int'(hour_ones) != mon_e.hour % 10 ||
          int'(disp_tens) != mon_e.disp / 10 || int'(disp_ones) != mon_e.disp % 10 ||
          pm != mon_e.pm || day_COUT != mon_e.day) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t: got hour=%0d%0d disp=%0d%0d pm=%0b day=%0b, want hour=%02d disp=%02d pm=%0b day=%0b",
                 $time, hour_tens, hour_ones, disp_tens, disp_ones, pm, day_COUT,
                 mon_e.hour, mon_e.disp, mon_e.pm, mon_e.day);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
    #2;
  endtask

  task automatic cin_pulse();
    hour_CIN = 1'b0;
    cyc(1);
    hour_CIN = 1'b1;
    cyc(2);
  endtask

  task automatic press_key();
    key_inc = 1'b0;
    cyc(2);
    key_inc = 1'b1;
    cyc(4);
  endtask

  initial begin
    RST = 1'b1; EN_work = 1'b0; EN_set = 1'b1; hour_CIN = 1'b1; key_inc = 1'b1; mode_12h = 1'b0;
    cyc(3);
    RST = 1'b0;
    // Carry held high across reset release must not count.
    cyc(6);
    cin_pulse();
    cyc(3);
    // Walk up to 22, then 23 and the day rollover.
    repeat (21) cin_pulse();
    cyc(2);
    cin_pulse();
    cin_pulse();
    cyc(3);
    // A long carry level yields a single increment.
    hour_CIN = 1'b0;
    cyc(1);
    hour_CIN = 1'b1;
    cyc(1000);
    // Set mode: hold key past delay and several repeat periods.
    EN_set = 1'b0;
    cyc(2);
    key_inc = 1'b0;
    cyc(S + 15);
    key_inc = 1'b1;
    cyc(6);
    // Carry edges during set mode are dropped.
    cin_pulse();
    cin_pulse();
    // Set to 23 then wrap via key: no day pulse.
    while (m_hour != 23) press_key();
    press_key();
    // Hold mode ignores key and carry.
    EN_set = 1'b1; EN_work = 1'b1;
    press_key();
    cin_pulse();
    // 12 h display sweep over every hour, toggling mode midway.
    EN_set = 1'b0; mode_12h = 1'b1;
    cyc(2);
    for (int i = 0; i < 24; i++) begin
      press_key();
      if (i == 12) begin
        mode_12h = 1'b0;
        cyc(2);
        mode_12h = 1'b1;
      end
    end
    // Leave set mode mid-repeat with key held; re-entry needs a fresh press.
    key_inc = 1'b0;
    cyc(S + 10);
    EN_set = 1'b1;
    cyc(15);
    EN_set = 1'b0;
    cyc(15);
    key_inc = 1'b1;
    cyc(4);
    press_key();
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0)  key_inc  = ~key_inc;
      if ($urandom_range(0, 3) == 0)  hour_CIN = ~hour_CIN;
      if ($urandom_range(0, 39) == 0) EN_set   = ~EN_set;
      if ($urandom_range(0, 39) == 0) EN_work  = ~EN_work;
      if ($urandom_range(0, 59) == 0) mode_12h = ~mode_12h;
      cyc(1);
    end
    // Reset asserted mid-DELAY: outputs clear without waiting for a clock edge.
    EN_set = 1'b0; key_inc = 1'b1;
    cyc(S + 2);
    press_key();
    key_inc = 1'b0;
    cyc(S + 3);
    RST = 1'b1;
    #1;
    checks++;
    if ({hour_tens, hour_ones, disp_tens, disp_ones, pm, day_COUT} != 18'd0) begin
      errors++;
      $display("FAIL async_reset: got hour=%0d%0d disp=%0d%0d pm=%0b day=%0b, want all zero",
               hour_tens, hour_ones, disp_tens, disp_ones, pm, day_COUT);
    end
    cyc(2);
    RST = 1'b0;
    cyc(S + 4);
    key_inc = 1'b1;
    cyc(5);
    checks++;
    if (sb_q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want at most 1", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hour_counter_24.md
Name: hour_counter_24

Overview:
- BCD hour counter stage directly downstream of the seconds/minutes carry generator in the clock/alarm datapath.
- Consumes the hour carry level, counts 00–23 in BCD, and supports manual hour setting from a key with auto-repeat.
- Produces raw 24 h digits for the alarm comparator, plus registered 12/24 h display digits, a PM flag and a day-rollover pulse.

Parameters:
- REPEAT_DELAY, 500, CLK cycles a key must stay held before auto-repeat starts.
- REPEAT_PERIOD, 200, CLK cycles between auto-repeat increments.
- SYNC_STAGES, 2, flop stages synchronising key_inc.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN_work  in  1  active-low run enable; counting allowed when 0.
- EN_set  in  1  active-low set mode; set mode when 0.
- hour_CIN  in  1  hour carry level from the carrier stage, same clock domain; may stay high for many cycles.
- key_inc  in  1  active-low debounced increment key, asynchronous.
- mode_12h  in  1  1 = 12 h display, 0 = 24 h display.
- hour_ones  out  4  internal 24 h BCD ones digit.
- hour_tens  out  4  internal 24 h BCD tens digit, value 0–2.
- disp_ones  out  4  display BCD ones digit.
- disp_tens  out  4  display BCD tens digit.
- pm  out  1  PM indicator; 12 h mode only.
- day_COUT  out  1  one-cycle pulse on the 23→00 rollover in run mode.

Behaviour:
- Reset, asynchronous: hour = 00, disp = 00, pm = 0, day_COUT = 0, key FSM = IDLE, edge registers cleared.
- Carry edge:
  - cin_rise = hour_CIN & ~hour_CIN_q; one increment per rising edge, regardless of level duration.
  - An edge that would fire while hour_CIN is already high out of reset is suppressed, because hour_CIN_q resets to 1.
- Mode priority: set mode (EN_set = 0) > run (EN_work = 0, EN_set = 1) > hold (both 1).
  - In set mode, cin_rise is ignored and not queued.
  - In hold, hour is frozen and key presses are ignored.
- Run increment: on cin_rise, the hour advances next cycle.
  - Ones 9→0 with tens +1.
  - 23→00 wraps, and day_COUT = 1 in that same cycle only.
- Key FSM (set mode only). The key is synchronised over SYNC_STAGES flops, then inverted to "pressed".
  - IDLE: press detected → one increment, go to DELAY, timer cleared.
  - DELAY: release → IDLE; timer reaches REPEAT_DELAY−1 → one increment, go to REPEAT, timer cleared.
  - REPEAT: release → IDLE; timer reaches REPEAT_PERIOD−1 → one increment, timer cleared.
  - Leaving set mode from any state → IDLE next cycle with no increment; a key still held must be released and pressed again.
  - Set-mode increments wrap 23→00 with no day_COUT.
- Internal hour_ones/tens are registered state, so they update in the cycle after the increment event.
- Display registers update one cycle after the internal hour changes (latency 1).
  - 24 h mode: disp = hour, pm = 0.
  - 12 h mode:
    - 00 → 12, pm = 0.
    - 01–11 → same value, pm = 0.
    - 12 → 12, pm = 1.
    - 13–23 → hour−12 in BCD, pm = 1.
  - A mode_12h change takes effect on the display 1 cycle later.
- Timers are wide enough for max(REPEAT_DELAY, REPEAT_PERIOD) and saturate; they never wrap.
- Digits are never outside valid BCD, and tens is never above 2.

Decomposition:
- Shared package clock_pkg:
  - BCD digit typedef, 4 bits.
  - Constants HOUR_MAX_TENS = 2, HOUR_MAX_ONES_AT_MAX_TENS = 3.
  - Key FSM state enum: IDLE, DELAY, REPEAT.
  - Function bcd_inc_hour (23→00 wrap) and function to_12h. The minute/second counters reuse the BCD helpers.
- One sub-module, key_repeat: synchroniser, press detection, and the DELAY/REPEAT FSM with timer. Its output is a single-cycle inc_pulse, and its enable is tied to set mode.

Test Plan:
- Reset with hour_CIN held high, EN_work = 0 → hour stays 00 (no spurious edge); one low-then-high pulse on hour_CIN → hour = 01 and disp = 01 one cycle later.
- Run at 22, two hour_CIN rising edges → 23, then 00 with day_COUT high exactly 1 cycle; a hour_CIN level held 1000 cycles produces only one increment.
- Set mode with REPEAT_DELAY = 5, REPEAT_PERIOD = 3, key held 14 cycles after sync → increments at press, +5, +8, +11, +14 (5 total); release returns FSM to IDLE.
- Set mode at 23 with one key press → 00 and day_COUT stays 0; a hour_CIN edge during set mode → no change.
- 12 h mode sweep through 00, 01, 11, 12, 13, 23 → display 12/0, 01/0, 11/0, 12/1, 01/1, 11/1 (digits/pm).
- Key held while EN_set goes 0→1 mid-REPEAT → no further increments; RST asserted mid-DELAY → all outputs 0 immediately and FSM back in IDLE.
